// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with open-drain line control,
// request-to-send sequencing, device-clocked shifting, ACK check and timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES     = 5000,
  parameter int FIRST_EDGE_TIMEOUT = 750000,
  parameter int BIT_TIMEOUT        = 100000,
  parameter int CNT_W              = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE, ERROR} state_t;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRST_TO = CNT_W'(FIRST_EDGE_TIMEOUT);
  localparam logic [CNT_W-1:0] BIT_TO   = CNT_W'(BIT_TIMEOUT);
  state_t           state_q, state_d;
  logic [1:0]       clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_q, bit_d;
  logic             data_low_q, data_low_d;
  logic             clk_s, data_s, fall, timeout;
  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign fall    = clk_prev_q & ~clk_s;
  assign timeout = cnt_q >= ((state_q == RTS) ? FIRST_TO : BIT_TO);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      data_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      data_low_q  <= data_low_d;
    end
  end
  // Every edge restarts the cycle counter, so an edge always beats a same-cycle timeout.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_prev_d  = clk_s;
    state_d     = state_q;
    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    shift_d     = shift_q;
    bit_d       = bit_q;
    data_low_d  = data_low_q;
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        data_low_d = 1'b0;
        if (tx_valid) begin
          state_d = INHIBIT;
          shift_d = {1'b1, ~^tx_data, tx_data};
          bit_d   = '0;
        end
      end
      INHIBIT: if (cnt_q >= INH_LAST) begin
        state_d    = RTS;
        cnt_d      = '0;
        data_low_d = 1'b1;
      end
      RTS, SHIFT: begin
        if (fall) begin
          cnt_d      = '0;
          data_low_d = ~shift_q[0];
          shift_d    = {1'b0, shift_q[9:1]};
          bit_d      = bit_q + 1'b1;
          state_d    = (bit_q == 4'd9) ? ACK : SHIFT;
        end else if (timeout) begin
          state_d    = ERROR;
          data_low_d = 1'b0;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = data_s ? ERROR : WAIT_IDLE;
        end else if (timeout) state_d = ERROR;
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) state_d = DONE;
        else if (fall) cnt_d = '0;
        else if (timeout) state_d = ERROR;
      end
      DONE, ERROR: begin
        state_d    = IDLE;
        data_low_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tx_ready           = state_q == IDLE;
    busy               = state_q != IDLE;
    tx_done            = state_q == DONE;
    tx_error           = state_q == ERROR;
    ps2_clk_drive_low  = state_q == INHIBIT;
    ps2_data_drive_low = data_low_q && (state_q == RTS || state_q == SHIFT);
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain bus model and a scaled-down device clock.
module tb_ps2_host_tx;
  localparam int INH = 40, FTO = 600, BTO = 300, H = 20;
  logic clk = 0, rst = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, busy, tx_done, tx_error, ps2_clk_in, ps2_data_in;
  logic ps2_clk_drive_low, ps2_data_drive_low;
  logic dev_clk = 1, dev_data = 1;
  int checks = 0, failures = 0, done_cnt = 0, err_cnt = 0;
  logic pulse_prev = 0;
  assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FIRST_EDGE_TIMEOUT(FTO), .BIT_TIMEOUT(BTO), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error), .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in), .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) begin
      failures++;
      $display("FAIL done_and_error: both high at %0t", $time);
    end
    if (pulse_prev && rst) check("ready_after_pulse", 32'(tx_ready), 32'd1);
    pulse_prev = rst & (tx_done | tx_error);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Accept a byte, measure the inhibit phase, return at the first RTS cycle.
  task automatic start_send(input logic [7:0] d);
    int inh;
    tx_data = d;
    tx_valid = 1;
    @(negedge clk);
    check("busy_in_inhibit", 32'({busy, tx_ready}), 32'b10);
    inh = 0;
    while (ps2_clk_drive_low && inh < 10000) begin
      if (inh == 1) begin tx_data = ~d; tx_valid = 1; end
      if (inh == 4) tx_valid = 0;
      inh++;
      @(negedge clk);
    end
    tx_valid = 0;
    check("inhibit_len", 32'(inh), 32'(INH));
    check("rts_drive", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'b01);
  endtask
  task automatic dev_edge();
    cyc(H);
    dev_clk = 0;
    cyc(H);
    dev_clk = 1;
  endtask
  task automatic send(input logic [7:0] d, input bit ack, output logic [10:0] frame,
                      output int dd, output int de);
    int bd, be, t;
    bd = done_cnt;
    be = err_cnt;
    start_send(d);
    for (int i = 0; i < 11; i++) begin
      cyc(H);
      frame[i] = ps2_data_in;
      if (i == 10 && ack) dev_data = 0;
      dev_clk = 0;
      cyc(H);
      dev_clk = 1;
      dev_data = 1;
    end
    t = 0;
    while (done_cnt == bd && err_cnt == be && t < 500) begin @(negedge clk); t++; end
    cyc(3);
    dd = done_cnt - bd;
    de = err_cnt - be;
  endtask
  typedef struct {logic [7:0] d; bit ack; logic [10:0] frame; int done; int err;} vec_t;
  vec_t v[5];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [10:0] fr;
    int dd, de, k, b;
    v[0] = '{8'hED, 1'b1, 11'b1_1_11101101_0, 1, 0};
    v[1] = '{8'hF4, 1'b1, 11'b1_0_11110100_0, 1, 0};
    v[2] = '{8'h00, 1'b1, 11'b1_1_00000000_0, 1, 0};
    v[3] = '{8'h81, 1'b1, 11'b1_1_10000001_0, 1, 0};
    v[4] = '{8'hF4, 1'b0, 11'b1_0_11110100_0, 0, 1};
    cyc(3);
    check("reset_outputs", 32'({tx_ready, busy, tx_done, tx_error, ps2_clk_drive_low, ps2_data_drive_low}),
          32'b100000);
    rst = 1;
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      send(v[i].d, v[i].ack, fr, dd, de);
      check($sformatf("frame_%0d", i), 32'(fr), 32'(v[i].frame));
      check($sformatf("done_%0d", i), 32'(dd), 32'(v[i].done));
      check($sformatf("err_%0d", i), 32'(de), 32'(v[i].err));
      cyc(2);
    end
    // Device never clocks after the clock release.
    b = err_cnt;
    start_send(8'hF4);
    k = 0;
    while (!tx_error && k < FTO + 50) begin @(negedge clk); k++; end
    check("first_edge_timeout", 32'(k >= FTO && k <= FTO + 2), 32'd1);
    check("first_to_release", 32'({ps2_clk_drive_low, ps2_data_drive_low, tx_done}), 32'b000);
    cyc(3);
    check("first_to_err_count", 32'(err_cnt - b), 32'd1);
    // Device stops after five edges.
    b = done_cnt;
    start_send(8'hAA);
    for (int i = 0; i < 4; i++) dev_edge();
    cyc(H);
    dev_clk = 0;
    k = 0;
    while (!tx_error && k < BTO + 100) begin
      @(negedge clk);
      k++;
      if (k == H) dev_clk = 1;
    end
    dev_clk = 1;
    check("bit_timeout", 32'(k >= BTO + 2 && k <= BTO + 6), 32'd1);
    check("bit_to_release", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'b00);
    cyc(3);
    check("bit_to_no_done", 32'(done_cnt - b), 32'd0);
    // Asynchronous reset in the middle of the data bits.
    start_send(8'h00);
    for (int i = 0; i < 4; i++) dev_edge();
    cyc(5);
    check("pre_rst_state", 32'({busy, ps2_data_drive_low}), 32'b11);
    #2 rst = 0;
    #1 check("rst_release_now", 32'({ps2_clk_drive_low, ps2_data_drive_low, tx_ready}), 32'b001);
    cyc(3);
    rst = 1;
    cyc(2);
    check("post_rst_idle", 32'({tx_ready, busy}), 32'b10);
    send(8'hFF, 1'b1, fr, dd, de);
    check("frame_ff", 32'(fr), 32'(11'b1_1_11111111_0));
    check("done_ff", 32'({dd[3:0], de[3:0]}), 32'h10);
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
